// File: rtl/sys_bus_reg_resp_if.sv
// ----------------------------------------------------------------------------
// sys_bus_reg_resp_if
// Simple register bus between a bus master and the sys_bus_reg_resp slave.
//   addr  [31:0]  bus address (slave decodes only the low AW bits)
//   wdata [31:0]  write data, qualified by wen
//   wen           single-cycle write request
//   ren           single-cycle read request
//   rdata [31:0]  read data, valid only while ack=1
//   err           error response, valid only while ack=1
//   ack           single-cycle transfer completion
// ----------------------------------------------------------------------------
interface sys_bus_reg_resp_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wen;
   logic        ren;
   logic [31:0] rdata;
   logic        err;
   logic        ack;

   modport master (
      output addr, wdata, wen, ren,
      input  rdata, err, ack
   );

   modport slave (
      input  addr, wdata, wen, ren,
      output rdata, err, ack
   );
endinterface

// File: rtl/sys_bus_reg_resp.sv
// ----------------------------------------------------------------------------
// sys_bus_reg_resp
// Bank of NR 32-bit control registers plus one status register on a simple
// request/acknowledge bus. Writes complete one cycle after wen, reads RL cycles
// after ren. Requests arriving while a transfer is in flight are dropped and
// latched in a sticky overflow flag, readable/clearable at offset NR*4.
//
// Optional feature (macro SYS_BUS_REG_RESP_SHADOW_EN):
//   defined   : bus writes land in shadow registers; upd_i copies all shadows
//               to the live outputs (a same-cycle write bypasses to live).
//   undefined : no shadow storage; writes update reg_o directly, upd_i ignored.
//
// Ports:
//   clk            system bus clock
//   rstn           asynchronous active-low reset
//   bus            sys_bus_reg_resp_if.slave (addr, wdata, wen, ren, rdata, err, ack)
//   upd_i          shadow-to-live update strobe
//   reg_o [NR*32]  live register values, register k at bits [32k+31:32k]
//   ovf_o          sticky dropped-request flag
// ----------------------------------------------------------------------------
module sys_bus_reg_resp #(
   parameter int unsigned      AW      = 20,
   parameter int unsigned      NR      = 16,
   parameter int unsigned      RL      = 2,
   parameter logic [NR*32-1:0] RST_VAL = '0
) (
   input  logic                 clk,
   input  logic                 rstn,
   sys_bus_reg_resp_if.slave    bus,
   input  logic                 upd_i,
   output logic [NR*32-1:0]     reg_o,
   output logic                 ovf_o
);

   localparam int unsigned LW       = $clog2(NR);
   localparam logic [1:0]  CNT_INIT = (RL > 1) ? 2'(RL - 2) : 2'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_ACK
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_cnt;
   logic [1:0]      w_cnt_nxt;

   // Transfer captured at the request edge, presented during ACK
   logic            r_rd;
   logic            r_err;
   logic            r_stat;
   logic [LW-1:0]   r_idx;
   logic            r_ovf;

   logic [AW-1:0]   w_off;
   logic [LW-1:0]   w_idx;
   logic            w_in_regs;
   logic            w_is_stat;
   logic            w_mapped;
   logic            w_idle;
   logic            w_wr_acc;
   logic            w_rd_acc;
   logic            w_drop;
   logic            w_wr_reg;
   logic            w_wr_clr;
   logic [31:0]     w_rd_src;
   logic            w_unused_addr;

   // ---------------------------------------------------------------- decode
   assign w_off         = bus.addr[AW-1:0];
   assign w_idx         = bus.addr[LW+1:2];
   // Register window: aligned and every offset bit above the index is zero
   assign w_in_regs     = (w_off[1:0] == 2'b00) && ((w_off >> (LW + 2)) == '0);
   assign w_is_stat     = (w_off == AW'(NR * 4));
   assign w_mapped      = w_in_regs || w_is_stat;
   // Address bits above the window are intentionally ignored
   assign w_unused_addr = ^bus.addr;

   // ------------------------------------------------------------- handshake
   assign w_idle   = (r_state == ST_IDLE);
   assign w_wr_acc = w_idle && bus.wen;
   assign w_rd_acc = w_idle && bus.ren && !bus.wen;
   // Write wins a simultaneous write/read; anything arriving while busy is lost
   assign w_drop   = (w_idle && bus.wen && bus.ren) || (!w_idle && (bus.wen || bus.ren));
   assign w_wr_reg = w_wr_acc && w_in_regs;
   assign w_wr_clr = w_wr_acc && w_is_stat && bus.wdata[0];

   // ------------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_IDLE: begin
            if (bus.wen) begin
               w_state_nxt = ST_ACK;
            end else if (bus.ren) begin
               if (RL == 1) begin
                  w_state_nxt = ST_ACK;
               end else begin
                  w_state_nxt = ST_RD_WAIT;
                  w_cnt_nxt   = CNT_INIT;
               end
            end
         end
         ST_RD_WAIT: begin
            if (r_cnt == 2'd0) begin
               w_state_nxt = ST_ACK;
            end else begin
               w_cnt_nxt = r_cnt - 2'd1;
            end
         end
         ST_ACK: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------- transfer capture
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rd   <= 1'b0;
         r_err  <= 1'b0;
         r_stat <= 1'b0;
         r_idx  <= '0;
      end else if (w_wr_acc) begin
         r_rd   <= 1'b0;
         r_err  <= !w_mapped;
         r_stat <= 1'b0;
      end else if (w_rd_acc) begin
         r_rd   <= 1'b1;
         r_err  <= !w_mapped;
         r_stat <= w_is_stat;
         r_idx  <= w_idx;
      end
   end

   // A dropped request in the same edge overrides a status clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (w_wr_clr) begin
         r_ovf <= 1'b0;
      end
   end

   // --------------------------------------------------------------- storage
`ifdef SYS_BUS_REG_RESP_SHADOW_EN
   logic [NR*32-1:0] r_shadow;
   logic [NR*32-1:0] r_live;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_shadow <= RST_VAL;
         r_live   <= RST_VAL;
      end else begin
         if (w_wr_reg) begin
            r_shadow[w_idx*32 +: 32] <= bus.wdata;
         end
         if (upd_i) begin
            r_live <= r_shadow;
            // Same-edge write bypasses the shadow into the live copy
            if (w_wr_reg) begin
               r_live[w_idx*32 +: 32] <= bus.wdata;
            end
         end
      end
   end

   assign w_rd_src = r_shadow[r_idx*32 +: 32];
`else
   logic [NR*32-1:0] r_live;
   logic             w_unused_upd;

   assign w_unused_upd = upd_i;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_live <= RST_VAL;
      end else if (w_wr_reg) begin
         r_live[w_idx*32 +: 32] <= bus.wdata;
      end
   end

   assign w_rd_src = r_live[r_idx*32 +: 32];
`endif

   // --------------------------------------------------------------- outputs
   // Read data is sampled from storage during the ACK cycle itself
   assign bus.ack = (r_state == ST_ACK);
   assign bus.err = bus.ack && r_err;

   always_comb begin
      bus.rdata = '0;
      if (bus.ack && r_rd && !r_err) begin
         bus.rdata = r_stat ? {31'b0, r_ovf} : w_rd_src;
      end
   end

   assign reg_o = r_live;
   assign ovf_o = r_ovf;

endmodule

// File: tb/tb_sys_bus_reg_resp.sv
// ----------------------------------------------------------------------------
// tb_sys_bus_reg_resp
// Self-checking bench for sys_bus_reg_resp (AW=20, NR=16, RL=3, non-zero reset
// image). A transaction-level reference model tracks register contents, the
// overflow flag and the cycle at which each accepted request must complete.
// Works with SYS_BUS_REG_RESP_SHADOW_EN defined or undefined.
// ----------------------------------------------------------------------------
module tb_sys_bus_reg_resp;

   localparam int unsigned AW = 20;
   localparam int unsigned NR = 16;
   localparam int unsigned RL = 3;

   function automatic logic [NR*32-1:0] mk_rst();
      logic [NR*32-1:0] r;
      r = '0;
      for (int i = 0; i < NR; i++) r[i*32 +: 32] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      return r;
   endfunction

   localparam logic [NR*32-1:0] TB_RST = mk_rst();

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              upd = 1'b0;
   logic [NR*32-1:0]  reg_o;
   logic              ovf_o;
   logic [NR*32-1:0]  rst_img;

   sys_bus_reg_resp_if bus ();

   sys_bus_reg_resp #(.AW(AW), .NR(NR), .RL(RL), .RST_VAL(TB_RST)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .bus   (bus),
      .upd_i (upd),
      .reg_o (reg_o),
      .ovf_o (ovf_o)
   );

   always #5 clk = ~clk;

   // ------------------------------------------------------ reference model
   logic [31:0]      m_sh [NR];
   logic [31:0]      m_lv [NR];
   bit               m_ovf;
   int               m_cyc;
   int               m_ack_cyc;
   bit               m_rd, m_err, m_stat;
   int               m_idx;
   bit               e_ack, e_err;
   logic [31:0]      e_rdata;
   logic [NR*32-1:0] e_reg;
   int               n_tests, n_fail;

   task automatic model_reset();
      for (int i = 0; i < NR; i++) begin
         m_sh[i] = rst_img[i*32 +: 32];
         m_lv[i] = rst_img[i*32 +: 32];
      end
      m_ovf = 0; m_ack_cyc = -100; m_rd = 0; m_err = 0; m_stat = 0; m_idx = 0;
   endtask

   function automatic bit decode(input logic [31:0] a, output int idx, output bit stat);
      longint off;
      off = longint'(a) % (longint'(1) << AW);
      idx = 0; stat = 0;
      if (off % 4 != 0) return 0;
      if (off < NR * 4) begin idx = int'(off / 4); return 1; end
      if (off == NR * 4) begin stat = 1; return 1; end
      return 0;
   endfunction

   function automatic logic [31:0] model_src(input int k);
`ifdef SYS_BUS_REG_RESP_SHADOW_EN
      return m_sh[k];
`else
      return m_lv[k];
`endif
   endfunction

   // Drive one cycle of inputs, advance the model across the clock edge and
   // compute the outputs expected in the following cycle.
   task automatic step(input bit w, input bit r, input logic [31:0] a,
                       input logic [31:0] d, input bit u);
      int idx; bit stat, ok, busy, drop;
      bus.wen = w; bus.ren = r; bus.addr = a; bus.wdata = d; upd = u;
      @(posedge clk);
      if (!rstn) begin
         model_reset();
      end else begin
         busy = (m_cyc <= m_ack_cyc);
         drop = (busy && (w || r)) || (!busy && w && r);
         ok   = decode(a, idx, stat);
`ifdef SYS_BUS_REG_RESP_SHADOW_EN
         if (u) for (int i = 0; i < NR; i++) m_lv[i] = m_sh[i];
`endif
         if (!busy && w) begin
            if (ok && !stat) begin
`ifdef SYS_BUS_REG_RESP_SHADOW_EN
               m_sh[idx] = d;
               if (u) m_lv[idx] = d;
`else
               m_lv[idx] = d;
`endif
            end
            if (ok && stat && d[0]) m_ovf = 0;
            m_rd = 0; m_err = !ok; m_ack_cyc = m_cyc + 1;
         end else if (!busy && r) begin
            m_rd = 1; m_err = !ok; m_stat = stat; m_idx = idx; m_ack_cyc = m_cyc + RL;
         end
         if (drop) m_ovf = 1;
      end
      m_cyc++;
      #1;
      e_ack   = (m_cyc == m_ack_cyc);
      e_err   = e_ack && m_err;
      e_rdata = (e_ack && m_rd && !m_err) ? (m_stat ? {31'b0, m_ovf} : model_src(m_idx)) : 32'h0;
      for (int i = 0; i < NR; i++) e_reg[i*32 +: 32] = m_lv[i];
   endtask

   // ------------------------------------------------------------------ tests
   task automatic test_reset();
      repeat (2) step(0, 0, 32'h0, 32'h0, 0);
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
      n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
      n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
      n_tests++; if (reg_o !== TB_RST) begin n_fail++; $display("FAIL reset_reg: got %h want %h", reg_o, TB_RST); end
      n_tests++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
      rstn = 1'b1;
      step(1, 0, 32'h4, 32'h1111_2222, 0);
      n_tests++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL first_edge_ack: got %b want 1", bus.ack); end
      step(0, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_write_update();
      logic [31:0] exp_pre;
`ifdef SYS_BUS_REG_RESP_SHADOW_EN
      exp_pre = 32'h1202_0202;
`else
      exp_pre = 32'hDEAD_BEEF;
`endif
      step(1, 0, 32'h8, 32'hDEAD_BEEF, 0);
      n_tests++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack: got %b want 1", bus.ack); end
      n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", bus.err); end
      n_tests++; if (reg_o[95:64] !== exp_pre) begin n_fail++; $display("FAIL wr_pre_upd: got %h want %h", reg_o[95:64], exp_pre); end
      step(0, 0, 32'h0, 32'h0, 0);
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_single: got %b want 0", bus.ack); end
      step(0, 0, 32'h0, 32'h0, 1);
      n_tests++; if (reg_o[95:64] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_post_upd: got %h want deadbeef", reg_o[95:64]); end
      step(0, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_read_latency();
      int first, nack; logic [31:0] rd; logic er;
      first = -1; nack = 0; rd = 'x; er = 'x;
      for (int k = 1; k <= 6; k++) begin
         if (k == 1) step(0, 1, 32'h8, 32'h0, 0); else step(0, 0, 32'h0, 32'h0, 0);
         if (bus.ack === 1'b1) begin nack++; if (first < 0) begin first = k; rd = bus.rdata; er = bus.err; end end
      end
      n_tests++; if (first != RL) begin n_fail++; $display("FAIL rd_latency: got %0d want %0d", first, RL); end
      n_tests++; if (nack != 1) begin n_fail++; $display("FAIL rd_ack_count: got %0d want 1", nack); end
      n_tests++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
      n_tests++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b want 0", er); end
   endtask

   task automatic test_unmapped();
      int first; logic [31:0] rd; logic er;
      first = -1; rd = 'x; er = 'x;
      for (int k = 1; k <= 6; k++) begin
         if (k == 1) step(0, 1, 32'h6, 32'h0, 0); else step(0, 0, 32'h0, 32'h0, 0);
         if (bus.ack === 1'b1 && first < 0) begin first = k; rd = bus.rdata; er = bus.err; end
      end
      n_tests++; if (first != RL) begin n_fail++; $display("FAIL unm_rd_latency: got %0d want %0d", first, RL); end
      n_tests++; if (er !== 1'b1) begin n_fail++; $display("FAIL unm_rd_err: got %b want 1", er); end
      n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unm_rd_data: got %h want 0", rd); end
      step(1, 0, 32'h0008_0000, 32'hFFFF_FFFF, 0);
      n_tests++; if (bus.ack !== 1'b1 || bus.err !== 1'b1) begin n_fail++; $display("FAIL unm_wr_resp: got ack=%b err=%b want ack=1 err=1", bus.ack, bus.err); end
      n_tests++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL unm_wr_rdata: got %h want 0", bus.rdata); end
      step(0, 0, 32'h0, 32'h0, 1);
      n_tests++; if (reg_o !== e_reg) begin n_fail++; $display("FAIL unm_no_change: got %h want %h", reg_o, e_reg); end
      n_tests++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL unm_ovf: got %b want 0", ovf_o); end
   endtask

   task automatic test_overflow();
      int nack; logic [31:0] rd;
      nack = 0; rd = 'x;
      for (int k = 1; k <= 6; k++) begin
         if (k == 1) step(0, 1, 32'h0, 32'h0, 0);
         else if (k == 2) step(1, 0, 32'h4, 32'hAAAA_AAAA, 0);
         else step(0, 0, 32'h0, 32'h0, 0);
         if (bus.ack === 1'b1) nack++;
      end
      n_tests++; if (nack != 1) begin n_fail++; $display("FAIL ovf_ack_count: got %0d want 1", nack); end
      n_tests++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_o); end
      n_tests++; if (reg_o[63:32] !== 32'h1111_2222) begin n_fail++; $display("FAIL ovf_wr_dropped: got %h want 11112222", reg_o[63:32]); end
      for (int k = 1; k <= 6; k++) begin
         if (k == 1) step(0, 1, NR * 4, 32'h0, 0); else step(0, 0, 32'h0, 32'h0, 0);
         if (bus.ack === 1'b1) rd = bus.rdata;
      end
      n_tests++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ovf_status_rd: got %h want 1", rd); end
      step(1, 0, NR * 4, 32'h1, 0);
      n_tests++; if (bus.ack !== 1'b1 || ovf_o !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got ack=%b ovf=%b want ack=1 ovf=0", bus.ack, ovf_o); end
      step(0, 0, 32'h0, 32'h0, 0);
      step(1, 1, NR * 4, 32'h1, 0);
      n_tests++; if (bus.ack !== 1'b1 || ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_drop_wins: got ack=%b ovf=%b want ack=1 ovf=1", bus.ack, ovf_o); end
      step(0, 0, 32'h0, 32'h0, 0);
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL ovf_no_rd_ack: got %b want 0", bus.ack); end
      step(1, 0, NR * 4, 32'h1, 0);
      step(0, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_bypass();
      step(1, 0, 32'h0, 32'h5, 1);
      n_tests++; if (reg_o[31:0] !== 32'h5) begin n_fail++; $display("FAIL bypass_reg0: got %h want 5", reg_o[31:0]); end
      n_tests++; if (reg_o[95:64] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL bypass_other: got %h want deadbeef", reg_o[95:64]); end
      step(0, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_reset_mid_read();
      int nack;
      nack = 0;
      step(0, 1, 32'h8, 32'h0, 0);
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      n_tests++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL rstrd_ack: got %b want 0", bus.ack); end
      n_tests++; if (reg_o !== TB_RST) begin n_fail++; $display("FAIL rstrd_reg: got %h want %h", reg_o, TB_RST); end
      n_tests++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL rstrd_ovf: got %b want 0", ovf_o); end
      step(0, 0, 32'h0, 32'h0, 0);
      rstn = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step(0, 0, 32'h0, 32'h0, 0);
         if (bus.ack === 1'b1) nack++;
      end
      n_tests++; if (nack != 0) begin n_fail++; $display("FAIL rstrd_stale_ack: got %0d acks want 0", nack); end
      step(1, 0, 32'h10, 32'h77, 0);
      n_tests++; if (bus.ack !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rstrd_next_wr: got ack=%b err=%b want ack=1 err=0", bus.ack, bus.err); end
      step(0, 0, 32'h0, 32'h0, 0);
   endtask

   task automatic test_random();
      bit w, r, u; int sel; logic [31:0] a, d;
      for (int i = 0; i < 500; i++) begin
         w = ($urandom_range(0, 99) < 30);
         r = ($urandom_range(0, 99) < 30);
         u = ($urandom_range(0, 99) < 15);
         if (i >= 495) begin w = 0; r = 0; end
         sel = int'($urandom_range(0, 9));
         d = $urandom;
         if (sel <= 5) a = 32'($urandom_range(0, NR - 1)) * 4;
         else if (sel == 6) a = NR * 4;
         else if (sel == 7) a = 32'($urandom_range(0, NR - 1)) * 4 + 32'($urandom_range(1, 3));
         else if (sel == 8) a = ($urandom & 32'hFFF0_0000) | (32'($urandom_range(0, NR - 1)) * 4);
         else a = $urandom;
         step(w, r, a, d, u);
         n_tests++; if (bus.ack !== e_ack) begin n_fail++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, bus.ack, e_ack); end
         n_tests++; if (bus.err !== e_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b want %b", i, bus.err, e_err); end
         n_tests++; if (bus.rdata !== e_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, bus.rdata, e_rdata); end
         n_tests++; if (reg_o !== e_reg) begin n_fail++; $display("FAIL rnd_reg[%0d]: got %h want %h", i, reg_o, e_reg); end
         n_tests++; if (ovf_o !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, ovf_o, m_ovf); end
      end
   endtask

   initial begin
      n_tests = 0; n_fail = 0; m_cyc = 0;
      rst_img = TB_RST;
      bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = '0; bus.wdata = '0;
      model_reset();
      test_reset();
      test_write_update();
      test_read_latency();
      test_unmapped();
      test_overflow();
      test_bypass();
      test_reset_mid_read();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
